mips_div_32: RTL and testbench
==============================

# mips_div_32

Multi-cycle 32-bit integer divider for the MIPS ALU, implementing DIV/DIVU semantics (quotient to LO, remainder to HI). It is the subtractive counterpart of the carry-lookahead adder: each iteration of a restoring radix-2 algorithm performs one 33-bit trial subtraction built as A + ~B + 1 on an instance of `cla_32`. The block sits beside the combinational ALU and talks to the issue logic over a valid/ready request channel and a valid/ready result channel.

## Interface
- `WIDTH`, 32, operand width; only 32 is supported.
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `req_valid`  input  1  request present
- `req_ready`  output  1  divider idle, request can be accepted
- `dividend`  input  32  numerator, sampled on acceptance
- `divisor`  input  32  denominator, sampled on acceptance
- `is_signed`  input  1  1 = DIV, 0 = DIVU (only present with `DIV_SIGNED_EN`)
- `res_valid`  output  1  result available
- `res_ready`  input  1  consumer takes result
- `quotient`  output  32  LO value
- `remainder`  output  32  HI value
- `div_by_zero`  output  1  divisor was zero for this result

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `req_ready`=1. On `req_valid`&`req_ready`: latch operands, clear 33-bit partial remainder, load quotient register with |dividend|, iteration counter = 0. If divisor == 0 go to DONE, else CALC.
- CALC: each cycle shift {rem, quo} left by one; trial = rem − |divisor| (33-bit, via `cla_32` with inverted divisor and Cin=1, carry-out extends to bit 32). Trial non-negative: rem = trial, quo[0] = 1; else restore, quo[0] = 0. Counter increments; after the 32nd iteration (counter == 31) go to DONE.
- DONE: `res_valid`=1, outputs stable. On `res_ready` go to IDLE. `req_ready`=0 in CALC and DONE; no request queuing.
- Divide by zero: quotient = 32'hFFFF_FFFF, remainder = dividend (raw), `div_by_zero`=1.
- Signed (macro enabled, `is_signed`=1): operate on magnitudes; negate quotient if operand signs differ; remainder takes dividend's sign. −2^31 / −1 yields quotient 32'h8000_0000, remainder 0, no flag.
- Outputs change only on entry to DONE; held unchanged while `res_valid`&!`res_ready`.

## Timing
- Reset (async, any state, including mid-CALC): state IDLE, `req_ready`=1, `res_valid`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, counter 0. In-flight operation discarded.
- Normal latency: acceptance edge = cycle 0; `res_valid` high after edge 33 (32 CALC cycles + DONE entry).
- Divide-by-zero latency: `res_valid` high after edge 1.
- Earliest next acceptance: the cycle after the `res_valid`&`res_ready` edge (`req_ready` combinational from state).
- `req_valid` while busy is ignored; requester must hold it until accepted.

## Configuration
- `MIPS_DIV_SIGNED_EN` defined: `is_signed` port exists; magnitude conversion on entry and sign fix-up on DONE entry are implemented.
- Not defined: `is_signed` port absent; all operations unsigned (DIVU only); no sign logic synthesised.

## Structure
- Shared package `mips_alu_pkg`: `WIDTH` constant, state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2), divide-by-zero quotient constant 32'hFFFF_FFFF.
- Sub-module: existing `cla_32` instantiated once for the trial subtraction; no other children.

## Test plan
- DIVU 100 / 7 -> after 33 cycles quotient 14, remainder 2, `div_by_zero`=0; `req_ready` low throughout.
- DIVU 32'hFFFF_FFFF / 1 -> quotient 32'hFFFF_FFFF, remainder 0; 7 / 9 -> quotient 0, remainder 7.
- Divisor 0, dividend 32'h1234_5678 -> `res_valid` after 1 cycle, quotient 32'hFFFF_FFFF, remainder 32'h1234_5678, `div_by_zero`=1.
- Signed (macro on): −7 / 2 -> quotient −3 (32'hFFFF_FFFD), remainder −1; 7 / −2 -> quotient −3, remainder 1; 32'h8000_0000 / −1 -> quotient 32'h8000_0000, remainder 0.
- Back-pressure: hold `res_ready`=0 for 10 cycles -> outputs stable, new `req_valid` not accepted; release -> IDLE next cycle, next request accepted.
- Assert `rst` at CALC iteration 15 -> all outputs 0, `req_ready`=1 immediately; following 100 / 7 completes correctly.
- Random: 1000 DIVU operand pairs checked against `/` and `%` reference model.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared MIPS ALU definitions: operand width, divider state encoding and
// divide-by-zero constants, plus the magnitude helper used by signed division.
package mips_alu_pkg;

   localparam int unsigned WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

   // Two's-complement magnitude; -2^31 maps to 32'h8000_0000 read as unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/cla_32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with rippled group carries.
module cla_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [31:0] g;
   logic [31:0] p;
   logic [32:0] c;
   logic        grp_g;
   logic        grp_p;

   always_comb begin
      g     = a & b;
      p     = a ^ b;
      c     = '0;
      c[0]  = cin;
      grp_g = 1'b0;
      grp_p = 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
         int unsigned s;
         s = 4 * k;
         c[s+1] = g[s] | (p[s] & c[s]);
         c[s+2] = g[s+1] | (p[s+1] & g[s]) | (p[s+1] & p[s] & c[s]);
         c[s+3] = g[s+2] | (p[s+2] & g[s+1]) | (p[s+2] & p[s+1] & g[s])
                | (p[s+2] & p[s+1] & p[s] & c[s]);
         grp_g  = g[s+3] | (p[s+3] & g[s+2]) | (p[s+3] & p[s+2] & g[s+1])
                | (p[s+3] & p[s+2] & p[s+1] & g[s]);
         grp_p  = p[s+3] & p[s+2] & p[s+1] & p[s];
         c[s+4] = grp_g | (grp_p & c[s]);
      end
      sum  = p ^ c[31:0];
      cout = c[32];
   end

endmodule

// File: rtl/mips_div_32.sv
// Multi-cycle restoring radix-2 divider (DIV/DIVU: quotient -> LO, remainder -> HI).
// Define MIPS_DIV_SIGNED_EN to add the is_signed port and signed DIV support.
module mips_div_32
   import mips_alu_pkg::*;
#(
   parameter int unsigned WIDTH = mips_alu_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef MIPS_DIV_SIGNED_EN
   input  logic             is_signed,
`endif
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   div_state_t       state;
   div_state_t       state_next;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic [4:0]       cnt;

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             carry;
   logic             trial_ok;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] q_final;
   logic [WIDTH-1:0] r_final;
   logic             last_iter;
   logic             accept;
   logic             dvnd_neg;
   logic             dvsr_neg;

`ifdef MIPS_DIV_SIGNED_EN
   logic             neg_q;
   logic             neg_r;

   assign dvnd_neg = is_signed & dividend[WIDTH-1];
   assign dvsr_neg = is_signed & divisor[WIDTH-1];
   assign q_final  = neg_q ? (~quo_next + 1'b1) : quo_next;
   assign r_final  = neg_r ? (~rem_next[WIDTH-1:0] + 1'b1) : rem_next[WIDTH-1:0];
`else
   assign dvnd_neg = 1'b0;
   assign dvsr_neg = 1'b0;
   assign q_final  = quo_next;
   assign r_final  = rem_next[WIDTH-1:0];
`endif

   // Trial subtraction: low 32 bits through the CLA as rem + ~dvsr + 1; bit 32
   // adds shifted[32] + 1 + carry, so the 33-bit result is non-negative exactly
   // when that column carries out.
   assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};

   cla_32 u_cla (
      .a    (shifted[WIDTH-1:0]),
      .b    (~dvsr),
      .cin  (1'b1),
      .sum  (diff),
      .cout (carry)
   );

   assign trial_ok  = shifted[WIDTH] | carry;
   assign rem_next  = trial_ok ? {shifted[WIDTH] ~^ carry, diff} : shifted;
   assign quo_next  = {quo[WIDTH-2:0], trial_ok};
   assign last_iter = (cnt == 5'd31);
   assign accept    = req_valid & req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      res_valid  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = (divisor == '0) ? DONE : CALC;
         end
         CALC: begin
            if (last_iter) state_next = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem         <= '0;
         quo         <= '0;
         dvsr        <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef MIPS_DIV_SIGNED_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         if (state == IDLE && accept) begin
            rem  <= '0;
            quo  <= magnitude(dividend, dvnd_neg);
            dvsr <= magnitude(divisor, dvsr_neg);
            cnt  <= '0;
`ifdef MIPS_DIV_SIGNED_EN
            neg_q <= dvnd_neg ^ dvsr_neg;
            neg_r <= dvnd_neg;
`endif
            if (divisor == '0) begin
               quotient    <= DIV0_QUOTIENT;
               remainder   <= dividend;
               div_by_zero <= 1'b1;
            end
         end else if (state == CALC) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 5'd1;
            if (last_iter) begin
               quotient    <= q_final;
               remainder   <= r_final;
               div_by_zero <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mips_div_32.sv
// Self-checking bench for mips_div_32: directed cases, back-pressure, mid-op
// reset and randomized DIVU (plus DIV when MIPS_DIV_SIGNED_EN is defined).
module tb_mips_div_32;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        sgn;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mips_div_32 #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef MIPS_DIV_SIGNED_EN
      .is_signed   (sgn),
`endif
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // MIPS DIV/DIVU result rules expressed with plain arithmetic.
   function automatic void ref_div(input logic [31:0] n, input logic [31:0] d,
                                   input logic s, output logic [31:0] q,
                                   output logic [31:0] r, output logic z);
      int signed sn, sd;
      z = (d == 0);
      if (z) begin
         q = 32'hFFFF_FFFF;
         r = n;
      end else if (s) begin
         sn = n;
         sd = d;
         if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
         end else begin
            q = sn / sd;
            r = sn % sd;
         end
      end else begin
         q = n / d;
         r = n % d;
      end
   endfunction

   task automatic wait_ready();
      int w = 0;
      while (!req_ready && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
   endtask

   task automatic run_op(input logic [31:0] n, input logic [31:0] d,
                         input logic s, input int hold);
      logic [31:0] q_exp, r_exp;
      logic        z_exp;
      int          lat;
      logic        busy_ready;
      ref_div(n, d, s, q_exp, r_exp, z_exp);
      wait_ready();
      dividend  = n;
      divisor   = d;
      sgn       = s;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      lat        = 1;
      busy_ready = 1'b0;
      while (!res_valid && lat < 64) begin
         if (req_ready) busy_ready = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), (d == 0) ? 32'd1 : 32'd33);
      chk("busy_req_ready", 32'(busy_ready), 32'd0);
      chk("quotient", quotient, q_exp);
      chk("remainder", remainder, r_exp);
      chk("div_by_zero", 32'(div_by_zero), 32'(z_exp));
      if (hold > 0) begin
         dividend  = 32'd999;
         divisor   = 32'd3;
         req_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_quotient", quotient, q_exp);
            chk("hold_remainder", remainder, r_exp);
         end
         req_valid = 1'b0;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("release_idle", 32'(req_ready), 32'd1);
      chk("release_valid", 32'(res_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] n, d;
      rst       = 1'b1;
      req_valid = 1'b0;
      res_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      sgn       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(32'd100, 32'd7, 1'b0, 0);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
      run_op(32'd7, 32'd9, 1'b0, 0);
      run_op(32'h1234_5678, 32'd0, 1'b0, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
      run_op(32'd12345, 32'd100, 1'b0, 10);
      run_op(32'd50, 32'd0, 1'b0, 3);
      // Next request must be accepted right after the back-pressured one.
      run_op(32'd81, 32'd9, 1'b0, 0);

`ifdef MIPS_DIV_SIGNED_EN
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
      run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
      run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 0);
      run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 0);
      run_op(32'h8000_0000, 32'd1, 1'b1, 0);
`endif

      // Asynchronous reset in the middle of an operation.
      wait_ready();
      dividend  = 32'd100;
      divisor   = 32'd7;
      sgn       = 1'b0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (15) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_res_valid", 32'(res_valid), 32'd0);
      chk("midrst_quotient", quotient, 32'd0);
      chk("midrst_remainder", remainder, 32'd0);
      chk("midrst_div_by_zero", 32'(div_by_zero), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_op(32'd100, 32'd7, 1'b0, 0);

      for (int i = 0; i < 1000; i++) begin
         n = $urandom;
         d = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 49) == 0) d = 32'd0;
         run_op(n, d, 1'b0, 0);
      end

`ifdef MIPS_DIV_SIGNED_EN
      for (int i = 0; i < 200; i++) begin
         n = $urandom;
         d = $urandom;
         if ($urandom_range(0, 1) == 1) d = 32'($signed(d) >>> $urandom_range(0, 31));
         run_op(n, d, 1'b1, 0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
